// File: rtl/board_io_conditioner.sv
// Board I/O conditioner: synchronised, debounced switch inputs with edge
// pulses, plus LED PWM channels sharing one free-running counter.
module board_io_conditioner #(
  parameter int N_IN            = 7,
  parameter int N_OUT           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PWM_W           = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [N_IN-1:0]        raw_i,
  output logic [N_IN-1:0]        in_o,
  output logic [N_IN-1:0]        rise_o,
  output logic [N_IN-1:0]        fall_o,
  input  logic [N_OUT-1:0]       led_en_i,
  input  logic [N_OUT*PWM_W-1:0] duty_i,
  output logic [N_OUT-1:0]       pwm_o,
  output logic                   period_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PWM_W-1:0] P_LAST = '1;
  localparam logic [PWM_W-1:0] P_PRE = {{(PWM_W-1){1'b1}}, 1'b0};

  logic [N_IN-1:0]  r_s1;
  logic [N_IN-1:0]  r_s2;
  logic [N_IN-1:0]  r_stable;
  logic [N_IN-1:0]  r_rise;
  logic [N_IN-1:0]  r_fall;
  logic [CW-1:0]    r_cnt [N_IN];

  logic [PWM_W-1:0] r_pcnt;
  logic             r_period;
  logic [PWM_W-1:0] r_shadow [N_OUT];
  logic [N_OUT-1:0] r_pwm;

  logic [N_IN-1:0]  w_diff;
  logic             w_wrap;

  assign w_diff = r_s2 ^ r_stable;
  assign w_wrap = (r_pcnt == P_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      for (int i = 0; i < N_IN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1 <= raw_i;
      r_s2 <= r_s1;
      for (int i = 0; i < N_IN; i++) begin
        r_rise[i] <= 1'b0;
        r_fall[i] <= 1'b0;
        if (!w_diff[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != C_LAST) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else begin
          // mismatch has persisted long enough: accept new level
          r_cnt[i]    <= '0;
          r_stable[i] <= r_s2[i];
          r_rise[i]   <= r_s2[i];
          r_fall[i]   <= ~r_s2[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pcnt   <= '0;
      r_period <= 1'b0;
      r_pwm    <= '0;
      for (int c = 0; c < N_OUT; c++) begin
        r_shadow[c] <= '0;
      end
    end else begin
      r_pcnt   <= r_pcnt + PWM_W'(1);
      r_period <= (r_pcnt == P_PRE);
      for (int c = 0; c < N_OUT; c++) begin
        r_pwm[c] <= led_en_i[c] & (r_pcnt < r_shadow[c]);
        // duty only changes at the period boundary to avoid runt pulses
        if (w_wrap) begin
          r_shadow[c] <= duty_i[c*PWM_W +: PWM_W];
        end
      end
    end
  end

  assign in_o     = r_stable;
  assign rise_o   = r_rise;
  assign fall_o   = r_fall;
  assign pwm_o    = r_pwm;
  assign period_o = r_period;

endmodule

// File: tb/tb_board_io_conditioner.sv
// Randomised bench for board_io_conditioner with a behavioural
// run-length / cycle-phase reference model.
module tb_board_io_conditioner;

  localparam int NI  = 7;
  localparam int NO  = 4;
  localparam int D   = 16;
  localparam int W   = 8;
  localparam int PER = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] raw = '0;
  logic [NI-1:0] in_o;
  logic [NI-1:0] rise;
  logic [NI-1:0] fall;
  logic [NO-1:0] led_en = '0;
  logic [NO*W-1:0] duty = '0;
  logic [NO-1:0] pwm;
  logic          period;

  int n_checks = 0;
  int n_fail = 0;

  board_io_conditioner #(
    .N_IN(NI), .N_OUT(NO), .DEBOUNCE_CYCLES(D), .PWM_W(W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .raw_i(raw),
    .in_o(in_o), .rise_o(rise), .fall_o(fall),
    .led_en_i(led_en), .duty_i(duty),
    .pwm_o(pwm), .period_o(period)
  );

  always #5 clk = ~clk;

  // reference model: sampled pin history, mismatch run lengths, cycle phase
  logic [NI-1:0] m_s1 = '0;
  logic [NI-1:0] m_s2 = '0;
  logic [NI-1:0] m_stable = '0;
  logic [NI-1:0] m_rise = '0;
  logic [NI-1:0] m_fall = '0;
  int            m_run [NI];
  int            m_cyc = 0;
  int            m_ph = 0;
  int            m_shadow [NO];
  logic [NO-1:0] m_pwm = '0;
  logic          m_period = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0;
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < NI; i++) m_run[i] = 0;
      for (int c = 0; c < NO; c++) m_shadow[c] = 0;
      m_cyc = 0; m_pwm = '0; m_period = 1'b0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (m_s2[i] != m_stable[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == D) begin
          m_stable[i] = m_s2[i];
          m_rise[i] = m_s2[i];
          m_fall[i] = !m_s2[i];
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_ph = m_cyc % PER;
      for (int c = 0; c < NO; c++)
        m_pwm[c] = led_en[c] && (m_ph < m_shadow[c]);
      if (m_ph == PER - 1)
        for (int c = 0; c < NO; c++)
          m_shadow[c] = int'(duty[c*W +: W]);
      m_period = ((m_cyc + 1) % PER) == PER - 1;
      m_cyc++;
    end
  end

  task automatic wait_period(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < PER + 8; i++) begin
      @(negedge clk);
      if (period) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    raw = NI'($urandom);
    led_en = '1;
    duty = $urandom;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_o, rise, fall, pwm, period} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {in_o, rise, fall, pwm, period});
    end
    rst_n = 1'b1;
    raw = '0;
    for (int k = 1; k <= PER + 20; k++) begin
      @(negedge clk);
      if (k <= PER) begin
        n_checks++;
        if (pwm !== '0 || period !== (k == PER - 1)) begin
          n_fail++;
          $display("FAIL reset_pwm_hold k=%0d: pwm=%b period=%b expected pwm=0 period=%b",
                   k, pwm, period, (k == PER - 1));
        end
      end else begin
        n_checks++;
        if ({pwm, period} !== {m_pwm, m_period}) begin
          n_fail++;
          $display("FAIL reset_first_duty k=%0d: got %b expected %b",
                   k, {pwm, period}, {m_pwm, m_period});
        end
      end
    end
  endtask

  task automatic test_debounce_accept();
    raw = '0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (in_o !== '0) begin
      n_fail++;
      $display("FAIL accept_pre: in_o=%b expected 0", in_o);
    end
    raw[0] = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_o[0] !== (k >= 17) || rise[0] !== (k == 17) || fall[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL accept_timing k=%0d: in=%b rise=%b fall=%b expected in=%b rise=%b fall=0",
                 k, in_o[0], rise[0], fall[0], (k >= 17), (k == 17));
      end
      n_checks++;
      if ({in_o, rise, fall} !== {m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL accept_model k=%0d: got %h expected %h",
                 k, {in_o, rise, fall}, {m_stable, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_glitch();
    raw[2] = 1'b1;
    raw[0] = 1'b0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k == 9) begin
        raw[2] = 1'b0;
        raw[0] = 1'b1;
      end
      n_checks++;
      if (in_o[2] !== 1'b0 || rise[2] !== 1'b0 || fall[2] !== 1'b0 ||
          in_o[0] !== 1'b1 || fall[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch k=%0d: ch2 in/rise/fall=%b%b%b ch0 in/fall=%b%b expected 000 10",
                 k, in_o[2], rise[2], fall[2], in_o[0], fall[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    raw[0] = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (in_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: in_o[0]=%b expected 1", in_o[0]);
    end
    #2 rst_n = 1'b0;
    raw[0] = 1'b1;
    #1;
    n_checks++;
    if ({in_o, rise, fall, pwm, period} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got %h expected 0",
               {in_o, rise, fall, pwm, period});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_o[0] !== (k >= 17) || rise[0] !== (k == 17) ||
          fall !== '0 || period !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_redebounce k=%0d: in=%b rise=%b fall=%b period=%b expected in=%b rise=%b",
                 k, in_o[0], rise[0], fall, period, (k >= 17), (k == 17));
      end
    end
  endtask

  task automatic test_debounce_random();
    int rises = 0;
    for (int k = 0; k < 700; k++) begin
      @(negedge clk);
      n_checks++;
      if ({in_o, rise, fall} !== {m_stable, m_rise, m_fall}) begin
        n_fail++;
        $display("FAIL deb_random k=%0d: got %h expected %h",
                 k, {in_o, rise, fall}, {m_stable, m_rise, m_fall});
      end
      n_checks++;
      if ((rise & fall) !== '0) begin
        n_fail++;
        $display("FAIL deb_exclusive k=%0d: rise=%b fall=%b expected disjoint",
                 k, rise, fall);
      end
      rises += $countones(rise);
      for (int i = 0; i < NI; i++)
        if ($urandom_range(0, 19) == 0) raw[i] = ~raw[i];
    end
    n_checks++;
    if (rises == 0) begin
      n_fail++;
      $display("FAIL deb_activity: rises=%0d expected >0", rises);
    end
  endtask

  task automatic test_pwm_duty64();
    bit ok;
    int hi;
    int pc;
    led_en = 4'b0001;
    duty = '0;
    duty[7:0] = 8'd64;
    wait_period(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL pwm64_timeout: period seen=%b expected 1", ok);
    end
    for (int w = 0; w < 2; w++) begin
      hi = 0;
      pc = 0;
      for (int k = 0; k < PER; k++) begin
        @(negedge clk);
        hi += int'(pwm[0]);
        pc += int'(period);
        n_checks++;
        if ({pwm, period} !== {m_pwm, m_period}) begin
          n_fail++;
          $display("FAIL pwm64_model k=%0d: got %b expected %b",
                   k, {pwm, period}, {m_pwm, m_period});
        end
      end
      n_checks++;
      if (hi != 64 || pc != 1) begin
        n_fail++;
        $display("FAIL pwm64_window w=%0d: highs=%0d periods=%0d expected 64 1",
                 w, hi, pc);
      end
    end
  endtask

  task automatic test_duty_change();
    bit ok;
    int hi = 0;
    led_en = 4'b0011;
    duty[15:8] = 8'd0;
    wait_period(ok);
    repeat (100) @(negedge clk);
    duty[15:8] = 8'd200;
    ok = 1'b0;
    for (int i = 0; i < PER + 8 && !ok; i++) begin
      @(negedge clk);
      ok = period;
      n_checks++;
      if (pwm[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL duty_change_hold i=%0d: pwm[1]=%b expected 0", i, pwm[1]);
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL duty_change_timeout: period seen=%b expected 1", ok);
    end
    for (int k = 0; k < PER; k++) begin
      @(negedge clk);
      hi += int'(pwm[1]);
    end
    n_checks++;
    if (hi != 200) begin
      n_fail++;
      $display("FAIL duty_change_window: highs=%0d expected 200", hi);
    end
  endtask

  task automatic test_duty_extremes();
    bit ok;
    int hi2 = 0;
    int hi3 = 0;
    led_en = '1;
    duty[23:16] = 8'd0;
    duty[31:24] = 8'd255;
    wait_period(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL extremes_timeout: period seen=%b expected 1", ok);
    end
    for (int k = 0; k < PER; k++) begin
      @(negedge clk);
      hi2 += int'(pwm[2]);
      hi3 += int'(pwm[3]);
    end
    n_checks++;
    if (hi2 != 0 || hi3 != 255) begin
      n_fail++;
      $display("FAIL extremes_window: highs ch2=%0d ch3=%0d expected 0 255",
               hi2, hi3);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (pwm[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL en_pre: pwm[3]=%b expected 1", pwm[3]);
    end
    led_en[3] = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pwm[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL en_off_next_edge: pwm[3]=%b expected 0", pwm[3]);
    end
  endtask

  task automatic test_pwm_random();
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      n_checks++;
      if ({pwm, period} !== {m_pwm, m_period}) begin
        n_fail++;
        $display("FAIL pwm_random k=%0d: got %b expected %b",
                 k, {pwm, period}, {m_pwm, m_period});
      end
      if ($urandom_range(0, 49) == 0) duty = $urandom;
      if ($urandom_range(0, 29) == 0)
        led_en[$urandom_range(0, NO-1)] ^= 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce_accept();
    test_glitch();
    test_reset_mid();
    test_debounce_random();
    test_pwm_duty64();
    test_duty_change();
    test_duty_extremes();
    test_pwm_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
